mem_access_unit: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register outputs (MemRead, MemWrite, ALURes, OP2).
- Runs one data-memory transaction per load/store over a req/ack bus.
- Raises a stall request to the hazard/stall controller until the access completes.
- Holds returned load data stable for the MEM/WB register.

---
 rtl/mem_access_unit_pkg.sv | 14 +
 rtl/mem_access_unit.sv | 93 +++++++++
 tb/tb_mem_access_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: FSM encoding, datapath width and stall-vector bit indices.
package mem_access_unit_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned STALL_MEM = 3;
    localparam int unsigned STALL_WB  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: one req/ack transaction per load/store, stalls the
// pipeline until completion and holds load data for the MEM/WB register.
module mem_access_unit #(
    parameter int unsigned DATA_W  = mem_access_unit_pkg::DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [DATA_W-1:0] ALURes_in,
    input  logic [DATA_W-1:0] OP2_in,
    input  logic              stall_hold,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              stallreq_mem,
    output logic [DATA_W-1:0] mem_rdata_out,
    output logic              mem_err
);

    import mem_access_unit_pkg::*;

    state_e     r_state;
    logic [7:0] r_cnt;
    logic       w_access;
    logic       w_is_wr;
    logic       w_aligned;

    assign w_access  = MemRead_in | MemWrite_in;
    assign w_is_wr   = MemWrite_in;
    assign w_aligned = (ALURes_in[1:0] == 2'b00);

    // Gated by reset so the stall controller never sees a request while reset is held.
    assign stallreq_mem = reset &&
                          (((r_state == IDLE) && w_access && w_aligned) || (r_state == REQ));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_cnt         <= 8'd0;
            dm_req        <= 1'b0;
            dm_we         <= 1'b0;
            dm_addr       <= '0;
            dm_wdata      <= '0;
            mem_rdata_out <= '0;
            mem_err       <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_access && w_aligned) begin
                        dm_req   <= 1'b1;
                        dm_we    <= w_is_wr;
                        dm_addr  <= ALURes_in;
                        dm_wdata <= OP2_in;
                        r_cnt    <= 8'd0;
                        r_state  <= REQ;
                    end else if (w_access) begin
                        // Misaligned access is dropped; the instruction continues as a NOP.
                        mem_err <= 1'b1;
                    end
                end
                REQ: begin
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        if (!dm_we) begin
                            mem_rdata_out <= dm_rdata;
                        end
                        r_state <= DONE;
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        dm_req        <= 1'b0;
                        mem_err       <= 1'b1;
                        mem_rdata_out <= '0;
                        r_state       <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (!stall_hold) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed load/store/error/reset scenarios, with
// expected bus requests, load data, stall-run lengths and error pulses checked by a monitor.
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        reset;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic [31:0] ALURes_in;
    logic [31:0] OP2_in;
    logic        stall_hold;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stallreq_mem;
    logic [31:0] mem_rdata_out;
    logic        mem_err;

    mem_access_unit #(
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemRead_in   (MemRead_in),
        .MemWrite_in  (MemWrite_in),
        .ALURes_in    (ALURes_in),
        .OP2_in       (OP2_in),
        .stall_hold   (stall_hold),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_ack       (dm_ack),
        .dm_rdata     (dm_rdata),
        .stallreq_mem (stallreq_mem),
        .mem_rdata_out(mem_rdata_out),
        .mem_err      (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } req_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_rd_q[$];
    int          exp_stall_q[$];
    int          exp_err_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        MemRead_in  = 1'b0;
        MemWrite_in = 1'b0;
        ALURes_in   = 32'h0;
        OP2_in      = 32'h0;
    endtask

    // One aligned access starting in IDLE; ends at the start of the following IDLE cycle
    // with the access inputs still driven so the caller can chain or clear.
    task automatic mem_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int waits, input bit give_ack,
                          input logic [31:0] rdata, input logic [31:0] exp_rd, input int hold);
        exp_req_q.push_back('{we: wr, addr: addr, wdata: wdata, len: waits + 1});
        exp_rd_q.push_back(exp_rd);
        exp_stall_q.push_back(waits + 2);
        if (!give_ack) exp_err_q.push_back(1);
        MemRead_in  = rd;
        MemWrite_in = wr;
        ALURes_in   = addr;
        OP2_in      = wdata;
        step();
        repeat (waits) step();
        if (give_ack) begin
            dm_ack   = 1'b1;
            dm_rdata = rdata;
        end
        step();
        dm_ack   = 1'b0;
        dm_rdata = 32'h5A5A_0F0F;
        if (hold > 0) begin
            stall_hold = 1'b1;
            for (int i = 0; i < hold; i++) begin
                chk("done_hold_rdata", mem_rdata_out, exp_rd);
                chk("done_hold_stall", {31'b0, stallreq_mem}, 32'd0);
                step();
            end
            stall_hold = 1'b0;
        end
        chk("done_rdata", mem_rdata_out, exp_rd);
        chk("done_stall", {31'b0, stallreq_mem}, 32'd0);
        step();
    endtask

    initial begin : monitor
        req_t cur;
        int   req_len;
        int   st_len;
        int   err_len;
        logic prev_req;
        logic prev_err;
        cur      = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, len: 0};
        req_len  = 0;
        st_len   = 0;
        err_len  = 0;
        prev_req = 1'b0;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (dm_req) begin
                if (!prev_req) begin
                    if (exp_req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got addr %h, expected no request at %0t",
                                 dm_addr, $time);
                        cur = '{we: dm_we, addr: dm_addr, wdata: dm_wdata, len: 0};
                    end else begin
                        cur = exp_req_q.pop_front();
                    end
                    req_len = 0;
                end
                req_len++;
                chk("req_we", {31'b0, dm_we}, {31'b0, cur.we});
                chk("req_addr", dm_addr, cur.addr);
                chk("req_wdata", dm_wdata, cur.wdata);
            end else if (prev_req) begin
                chk("req_len", req_len, cur.len);
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rdata_unexpected: got %h, expected no completion", mem_rdata_out);
                end else begin
                    chk("rdata", mem_rdata_out, exp_rd_q.pop_front());
                end
            end
            if (stallreq_mem) begin
                st_len++;
            end else if (st_len > 0) begin
                if (exp_stall_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_stall: got run %0d, expected none", st_len);
                end else begin
                    chk("stall_len", st_len, exp_stall_q.pop_front());
                end
                st_len = 0;
            end
            if (mem_err) begin
                if (!prev_err) begin
                    if (exp_err_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_err: got pulse, expected none at %0t", $time);
                    end else begin
                        void'(exp_err_q.pop_front());
                    end
                    chk("err_with_req_rise", {31'b0, dm_req & ~prev_req}, 32'd0);
                    err_len = 0;
                end
                err_len++;
            end else if (prev_err) begin
                chk("err_len", err_len, 32'd1);
            end
            prev_req = dm_req;
            prev_err = mem_err;
        end
    end

    initial begin : stimulus
        reset      = 1'b0;
        stall_hold = 1'b0;
        dm_ack     = 1'b0;
        dm_rdata   = 32'h0;
        clear_inputs();
        // Aligned load presented during reset must not raise a stall.
        MemRead_in = 1'b1;
        ALURes_in  = 32'h0000_0008;
        #3;
        chk("rst_stall", {31'b0, stallreq_mem}, 32'd0);
        chk("rst_req", {31'b0, dm_req}, 32'd0);
        chk("rst_addr", dm_addr, 32'd0);
        chk("rst_rdata", mem_rdata_out, 32'd0);
        chk("rst_err", {31'b0, mem_err}, 32'd0);
        repeat (2) step();
        clear_inputs();
        reset = 1'b1;
        step();

        // Zero-wait load chained straight into a 3-wait store.
        mem_op(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        mem_op(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 3, 1'b1, 32'hFFFF_FFFF,
               32'hDEAD_BEEF, 0);
        clear_inputs();
        step();

        // Misaligned load: error pulse only.
        exp_err_q.push_back(1);
        MemRead_in = 1'b1;
        ALURes_in  = 32'h0000_0013;
        chk("misaligned_stall", {31'b0, stallreq_mem}, 32'd0);
        step();
        clear_inputs();
        step();

        // Load held in DONE for 3 cycles, then back-to-back load that times out.
        mem_op(1'b1, 1'b0, 32'h0000_0030, 32'h0, 0, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 3);
        mem_op(1'b1, 1'b0, 32'h0000_0040, 32'h0, TO - 1, 1'b0, 32'h0, 32'h0, 0);
        clear_inputs();
        step();

        // Reset asserted during the second REQ cycle.
        exp_req_q.push_back('{we: 1'b0, addr: 32'h0000_0080, wdata: 32'h0, len: 1});
        exp_rd_q.push_back(32'h0);
        exp_stall_q.push_back(2);
        MemRead_in = 1'b1;
        ALURes_in  = 32'h0000_0080;
        step();
        step();
        #1 reset = 1'b0;
        #1;
        chk("midrst_req", {31'b0, dm_req}, 32'd0);
        chk("midrst_stall", {31'b0, stallreq_mem}, 32'd0);
        chk("midrst_addr", dm_addr, 32'd0);
        chk("midrst_we", {31'b0, dm_we}, 32'd0);
        chk("midrst_wdata", dm_wdata, 32'd0);
        chk("midrst_err", {31'b0, mem_err}, 32'd0);
        clear_inputs();
        step();
        step();
        reset = 1'b1;
        dm_ack   = 1'b1;
        dm_rdata = 32'hFFFF_0000;
        step();
        dm_ack = 1'b0;
        step();
        chk("late_ack_rdata", mem_rdata_out, 32'd0);
        chk("late_ack_req", {31'b0, dm_req}, 32'd0);

        // Recovery: one-wait load after reset.
        mem_op(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D, 0);
        clear_inputs();
        repeat (3) step();

        chk("req_q_empty", exp_req_q.size(), 32'd0);
        chk("rd_q_empty", exp_rd_q.size(), 32'd0);
        chk("stall_q_empty", exp_stall_q.size(), 32'd0);
        chk("err_q_empty", exp_err_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
